dircc_packet_tx: RTL
====================

// Module: dircc_packet_tx
// PURPOSE
//   Store-and-forward packet transmitter feeding the router's "here" input port (Avalon-ST, 32-bit, SOP/EOP/empty).
//   Local logic writes one message (payload words plus destination) into an internal buffer.
//   The block then emits a framed packet: destination header, source header (own address_address), then payload.
//   One message buffered at a time.
// PARAMETERS
//   DATA_W     32  data/header word width; must be 32
//   MAX_WORDS  16  payload buffer depth in words; power of two, >=2
//   CNT_W      5   counter width = log2(MAX_WORDS)+1
// PORTS
//   clk_clk            in   1       single clock, all logic rising-edge
//   reset_reset        in   1       synchronous, active-high reset
//   address_address    in   32      own node address, sampled into header word 1 at SOP handshake
//   wr_dest            in   32      destination address, sampled with first accepted payload word
//   wr_data            in   32      payload word
//   wr_valid           in   1       payload word valid
//   wr_last            in   1       marks final payload word
//   wr_empty           in   2       unused bytes in final word (valid with wr_last)
//   wr_ready           out  1       buffer accepting payload words
//   output_here_data   out  32      packet word to router input_here
//   output_here_valid  out  1       packet word valid
//   output_here_ready  in   1       router ready, readyLatency 0
//   output_here_startofpacket out 1 first word (destination header)
//   output_here_endofpacket   out 1 final payload word
//   output_here_empty  out  2       empty bytes; nonzero only on EOP word
//   busy               out  1       high from first accepted word until final handshake
//   tx_done            out  1       one-cycle pulse, cycle after final (EOP) handshake
//   err_overflow       out  1       one-cycle pulse when a message is truncated
// BEHAVIOUR
//   Reset: state IDLE, counters 0, buffer contents don't-care.
//   Reset outputs: wr_ready=1; valid/sop/eop/busy/tx_done/err_overflow=0; data=0; empty=0.
//   Reset mid-packet: packet abandoned, no EOP sent, outputs return to reset values the next cycle.
//   FSM states:
//     IDLE: wr_ready=1. Accepted word (wr_valid&wr_ready) -> store at [0], latch wr_dest, busy=1 -> LOAD.
//       Accepted word with wr_last -> SEND_DST directly.
//     LOAD: wr_ready=1. Words stored at wr_cnt++.
//       Accepted wr_last -> latch len=wr_cnt+1, empty=wr_empty -> SEND_DST.
//     SEND_DST: valid=1, sop=1, data=dest.
//     SEND_SRC: valid=1, data=address_address latched at SOP handshake.
//     PAYLOAD: valid=1, data=buf[rd_cnt]. eop=1 and empty=latched empty when rd_cnt==len-1.
//     Advance on each output handshake: SEND_DST -> SEND_SRC -> PAYLOAD -> IDLE after the EOP handshake.
//   wr_ready is 0 in all SEND states and PAYLOAD; no writes are accepted while transmitting.
//   Overflow: MAX_WORDS-th word accepted without wr_last is treated as last.
//     len=MAX_WORDS, empty=0, err_overflow pulses the next cycle, -> SEND_DST.
//     Remaining input words of that message are accepted and dropped until wr_last.
//     Use a DROP state between the overflow and SEND_DST; wr_ready=1 in DROP.
//   Latency: wr_last accepted in cycle T -> SOP valid in T+1.
//   With ready held high, a packet of N payload words takes N+2 consecutive cycles.
//   Output stability: while valid=1 and ready=0, data/sop/eop/empty are held unchanged.
//   valid never drops without a handshake.
//   empty forced 0 on every non-EOP word. sop and eop are never both 1, since packets are >=3 words.
//   tx_done pulses in the cycle after the EOP handshake; busy falls in the same cycle.
//   wr_ready=1 in that cycle, so back-to-back messages are accepted.
//   Counters: wr_cnt/rd_cnt are CNT_W bits and never wrap. rd_cnt resets to 0 on SOP handshake.
// TESTING
//   Write 3 words A,B,C (dest=0x0001_0002, last on C, empty=2), ready=1
//     -> 5 cycles: {0x00010002 sop}, {own addr}, A, B, {C eop empty=2}; tx_done next.
//   Same message, ready toggling 1,0,0,1,...
//     -> output words/flags held across stall cycles; exact 5-word sequence; no duplicate or skipped word.
//   Single-word message D with wr_last on first beat -> packet {dest sop}, {src}, {D eop}; SOP in cycle after accept.
//   Write 20 words, MAX_WORDS=16, last on word 20
//     -> err_overflow pulse once; packet carries words 1..16, eop on word 16, empty=0.
//     -> Words 17..20 are consumed and dropped.
//   Assert reset_reset during PAYLOAD word 2
//     -> next cycle valid=0, wr_ready=1, busy=0; a following message transmits correctly from SOP.
//   Two messages back-to-back, wr_valid held high
//     -> wr_ready=0 during transmission; second packet SOP follows the cycle after second wr_last accept.

Source files
------------

// File: rtl/dircc_packet_tx.sv
// Store-and-forward packet transmitter: buffers one message from local logic, then
// emits it to the router as {destination header, source header, payload...}.
module dircc_packet_tx #(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] address_address,
  input  logic [DATA_W-1:0] wr_dest,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  input  logic              wr_last,
  input  logic [1:0]        wr_empty,
  output logic              wr_ready,
  output logic [DATA_W-1:0] output_here_data,
  output logic              output_here_valid,
  input  logic              output_here_ready,
  output logic              output_here_startofpacket,
  output logic              output_here_endofpacket,
  output logic [1:0]        output_here_empty,
  output logic              busy,
  output logic              tx_done,
  output logic              err_overflow
);

  localparam int AW = CNT_W - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DROP,
    S_SEND_DST,
    S_SEND_SRC,
    S_PAYLOAD
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [1:0]        empty_q, empty_d;
  logic [DATA_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] src_q, src_d;
  logic              tx_done_q, tx_done_d;
  logic              err_overflow_q, err_overflow_d;

  logic [DATA_W-1:0] mem_q [MAX_WORDS];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_last;

  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    len_d          = len_q;
    empty_d        = empty_q;
    dest_d         = dest_q;
    src_d          = src_q;
    tx_done_d      = 1'b0;
    err_overflow_d = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = wr_cnt_q[AW-1:0];
    mem_wdata      = wr_data;
    rd_last        = (rd_cnt_q == len_q - 1'b1);

    wr_ready                  = 1'b0;
    output_here_valid         = 1'b0;
    output_here_startofpacket = 1'b0;
    output_here_endofpacket   = 1'b0;
    output_here_data          = '0;
    output_here_empty         = '0;

    unique case (state_q)
      S_IDLE, S_LOAD: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (state_q == S_IDLE) begin
            dest_d = wr_dest;
          end
          if (wr_last) begin
            len_d    = wr_cnt_q + 1'b1;
            empty_d  = wr_empty;
            wr_cnt_d = '0;
            state_d  = S_SEND_DST;
          end else if (wr_cnt_q == CNT_W'(MAX_WORDS - 1)) begin
            // buffer full without a last marker: truncate and discard the tail
            len_d          = CNT_W'(MAX_WORDS);
            empty_d        = '0;
            err_overflow_d = 1'b1;
            wr_cnt_d       = '0;
            state_d        = S_DROP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_DROP: begin
        wr_ready = 1'b1;
        if (wr_valid && wr_last) begin
          state_d = S_SEND_DST;
        end
      end
      S_SEND_DST: begin
        output_here_valid         = 1'b1;
        output_here_startofpacket = 1'b1;
        output_here_data          = dest_q;
        if (output_here_ready) begin
          src_d    = address_address;
          rd_cnt_d = '0;
          state_d  = S_SEND_SRC;
        end
      end
      S_SEND_SRC: begin
        output_here_valid = 1'b1;
        output_here_data  = src_q;
        if (output_here_ready) begin
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        output_here_valid       = 1'b1;
        output_here_data        = mem_q[rd_cnt_q[AW-1:0]];
        output_here_endofpacket = rd_last;
        output_here_empty       = rd_last ? empty_q : 2'b00;
        if (output_here_ready) begin
          if (rd_last) begin
            tx_done_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q        <= S_IDLE;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      len_q          <= '0;
      empty_q        <= '0;
      dest_q         <= '0;
      src_q          <= '0;
      tx_done_q      <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      len_q          <= len_d;
      empty_q        <= empty_d;
      dest_q         <= dest_d;
      src_q          <= src_d;
      tx_done_q      <= tx_done_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign tx_done      = tx_done_q;
  assign err_overflow = err_overflow_q;

endmodule
